multi_linebuffer: RTL

Multi-line circular line buffer for the vertical path of the axis scaler. One write port fills one line at a time. The read port returns the same column from the C_LINE_NUM most recently completed lines in a single registered word, as the vertical tap window for interpolation. Storage is C_LINE_NUM+1 line banks, so the line being written never aliases a readable tap. Selectable border mode covers the top of frame, before C_LINE_NUM lines exist.

---
 rtl/multi_linebuffer.sv | 101 ++++++++++
 1 files changed

// File: rtl/multi_linebuffer.sv
// Multi-line circular line buffer: one line is written at a time, and each read
// returns the same column from the C_LINE_NUM most recently completed lines.
module multi_linebuffer #(
    parameter int unsigned C_DATA_WIDTH    = 8,
    parameter int unsigned C_ADDRESS_WIDTH = 11,
    parameter int unsigned C_LINE_NUM      = 2,
    parameter int unsigned C_BORDER        = 1
) (
    input  logic                                clk,
    input  logic                                resetn,
    input  logic                                sof,
    input  logic                                wr_en,
    input  logic [C_ADDRESS_WIDTH-1:0]          wr_addr,
    input  logic [C_DATA_WIDTH-1:0]             wr_data,
    input  logic                                wr_eol,
    input  logic                                rd_en,
    input  logic [C_ADDRESS_WIDTH-1:0]          rd_addr,
    output logic [C_LINE_NUM*C_DATA_WIDTH-1:0]  rd_data,
    output logic                                rd_valid,
    output logic [$clog2(C_LINE_NUM+1)-1:0]     lines_filled
);

    localparam int unsigned DW    = C_DATA_WIDTH;
    localparam int unsigned DEPTH = 1 << C_ADDRESS_WIDTH;
    localparam int unsigned NB    = C_LINE_NUM + 1;
    localparam int unsigned BW    = $clog2(NB);
    localparam int unsigned LFW   = $clog2(C_LINE_NUM + 1);
    localparam int unsigned SW    = BW + 1;

    // One spare bank beyond the exposed taps keeps the write line out of the read window
    logic [DW-1:0]              mem [NB][DEPTH];
    logic [BW-1:0]              wl;
    logic [BW-1:0]              wr_bank;
    logic [C_LINE_NUM*DW-1:0]   rd_next;

    assign wr_bank = sof ? '0 : wl;

    // Line storage write; contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_bank][wr_addr] <= wr_data;
        end
    end

    // Write-bank pointer and completed-line count
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wl           <= '0;
            lines_filled <= '0;
        end else if (sof && wr_eol) begin
            wl           <= BW'(1);
            lines_filled <= LFW'(1);
        end else if (sof) begin
            wl           <= '0;
            lines_filled <= '0;
        end else if (wr_eol) begin
            wl <= (wl == BW'(C_LINE_NUM)) ? '0 : wl + BW'(1);
            if (lines_filled != LFW'(C_LINE_NUM)) begin
                lines_filled <= lines_filled + LFW'(1);
            end
        end
    end

    // Per-tap bank selection with border handling for lines not yet available
    for (genvar k = 0; k < C_LINE_NUM; k++) begin : g_tap
        logic           avail;
        logic [LFW-1:0] src;
        logic [SW-1:0]  sum;
        logic [BW-1:0]  bank;
        logic [DW-1:0]  tap;

        // Tap k reads bank (wl-1-src) mod NB, src falls back to the oldest line in replicate mode
        always_comb begin
            avail = (LFW'(k) < lines_filled);
            src   = avail ? LFW'(k) : lines_filled - LFW'(1);
            sum   = SW'(wl) + SW'(NB - 1) - SW'(src);
            bank  = (sum >= SW'(NB)) ? BW'(sum - SW'(NB)) : BW'(sum);
            if ((lines_filled == '0) || (!avail && (C_BORDER == 0))) begin
                tap = '0;
            end else begin
                tap = mem[bank][rd_addr];
            end
        end

        assign rd_next[k*DW +: DW] = tap;
    end

    // Registered read port, one-cycle latency, data held between reads
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_next;
            end
        end
    end

endmodule
